// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and flag indices for muldiv_iter
// Shared by muldiv_iter and muldiv_signfix.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL   = 3'b111;
  localparam logic [2:0] OP_UMULL = 3'b101;
  localparam logic [2:0] OP_SMULL = 3'b110;
  localparam logic [2:0] OP_UDIV  = 3'b100;
  localparam logic [2:0] OP_SDIV  = 3'b011;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_e;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_UDIV) || (op == OP_SDIV);
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return op_is_mul(op) || op_is_div(op);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_SMULL) || (op == OP_SDIV);
  endfunction

  function automatic logic op_is_long(input logic [2:0] op);
    return (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate of a WIDTH-bit value
// Used for operand magnitudes and for final sign correction.
module muldiv_signfix import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 iterative multiply/divide engine with start/busy/done handshake
// Divide datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_iter import muldiv_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             div_by_zero
);

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]     result_q, result_d, result_hi_q, result_hi_d;
  logic [3:0]           flags_q, flags_d;
  logic                 dbz_q, dbz_d, done_q, done_d;

  logic                 is_mul, sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic                 lo_zero, fix_hi_en;
  logic [WIDTH-1:0]     fix_lo, fix_hi, prod_hi;
  logic [WIDTH-1:0]     fin_lo, fin_hi;
  logic                 fin_dbz;
  logic [3:0]           fin_flags;

  assign is_mul = op_is_mul(op_q);
  assign sa     = op_is_signed(op_q) & a_q[WIDTH-1];
  assign sb     = op_is_signed(op_q) & b_q[WIDTH-1];

  muldiv_signfix #(.WIDTH(WIDTH)) u_mag_a (.val_i(a_q), .neg_i(sa), .val_o(mag_a));
  muldiv_signfix #(.WIDTH(WIDTH)) u_mag_b (.val_i(b_q), .neg_i(sb), .val_o(mag_b));

  // Shift-add step: acc = {partial high, remaining multiplier bits}.
  assign mul_addend = acc_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  // Restoring step: acc = {partial remainder, dividend bits shifting into quotient}.
  logic [WIDTH:0]       div_rem_sh, div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;

  assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff   = div_rem_sh - {1'b0, opnd_q};
  assign div_ok     = ~div_diff[WIDTH];
  assign div_next   = {(div_ok ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ok};
`endif

  // A negated 2*WIDTH product only carries into the high half when the low half is zero.
  assign lo_zero   = (acc_q[WIDTH-1:0] == '0);
  assign fix_hi_en = is_mul ? (neg_lo_q & lo_zero) : neg_hi_q;

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_lo (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .val_o(fix_lo));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_hi (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(fix_hi_en), .val_o(fix_hi));

  assign prod_hi = (is_mul && neg_lo_q && !lo_zero) ? ~acc_q[2*WIDTH-1:WIDTH] : fix_hi;

  always_comb begin
    fin_lo  = fix_lo;
    fin_hi  = prod_hi;
    fin_dbz = 1'b0;
    if (op_q == OP_MUL) begin
      fin_hi = '0;
    end
    if (op_is_div(op_q)) begin
`ifdef MULDIV_DIV_EN
      if (b_q == '0) begin
        fin_lo  = '1;
        fin_hi  = a_q;
        fin_dbz = 1'b1;
      end
`else
      fin_lo = '0;
      fin_hi = '0;
`endif
    end
    fin_flags         = 4'b0000;
    fin_flags[FLAG_N] = op_is_long(op_q) ? fin_hi[WIDTH-1] : fin_lo[WIDTH-1];
    fin_flags[FLAG_Z] = op_is_long(op_q) ? ({fin_hi, fin_lo} == '0) : (fin_lo == '0);
    fin_flags[FLAG_C] = 1'b0;
    fin_flags[FLAG_V] = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && op_is_legal(op)) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
`ifdef MULDIV_DIV_EN
          state_d = LOAD;
`else
          state_d = op_is_div(op) ? FIX : LOAD;
`endif
        end
      end
      LOAD: begin
        opnd_d   = is_mul ? mag_a : mag_b;
        acc_d    = {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
        cnt_d    = CNT_W'(WIDTH - 1);
        neg_lo_d = sa ^ sb;
        neg_hi_d = sa;
        state_d  = CALC;
      end
      CALC: begin
`ifdef MULDIV_DIV_EN
        acc_d = op_is_div(op_q) ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        result_d    = fin_lo;
        result_hi_d = fin_hi;
        flags_d     = fin_flags;
        dbz_d       = fin_dbz;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE) || done_q;
  assign done        = done_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign flags       = flags_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - self-checking bench for muldiv_iter (WIDTH=32), both MULDIV_DIV_EN builds
module tb_muldiv_iter;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [2:0] T_MUL = 3'b111, T_UMULL = 3'b101, T_SMULL = 3'b110,
                         T_UDIV = 3'b100, T_SDIV = 3'b011;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic         dbz;
    logic [3:0]   fl;
  } res_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic         clk, reset_n, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result, result_hi;
  logic [3:0]   flags;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .flags(flags), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic is_div(input logic [2:0] o);
    return (o == T_UDIV) || (o == T_SDIV);
  endfunction

  function automatic int exp_lat(input logic [2:0] o);
    return (is_div(o) && !DIV_EN) ? 1 : W + 2;
  endfunction

  function automatic res_t mk(input logic [W-1:0] r, rh, input logic dbz, input logic [3:0] fl);
    res_t x;
    x.r = r; x.rh = rh; x.dbz = dbz; x.fl = fl;
    return x;
  endfunction

  // Divide expectations collapse to the disabled-datapath values in the default build.
  function automatic res_t dv(input logic [W-1:0] r, rh, input logic dbz, input logic [3:0] fl);
    return DIV_EN ? mk(r, rh, dbz, fl) : mk('0, '0, 1'b0, 4'b0100);
  endfunction

  function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, y);
    res_t m;
    longint lx, ly;
    logic [63:0] p;
    int sx, sy;
    bit long_op;
    m = mk('0, '0, 1'b0, 4'b0000);
    long_op = (o == T_UMULL) || (o == T_SMULL);
    case (o)
      T_MUL:   begin p = {32'b0, x} * {32'b0, y}; m.r = p[31:0]; end
      T_UMULL: begin p = {32'b0, x} * {32'b0, y}; m.r = p[31:0]; m.rh = p[63:32]; end
      T_SMULL: begin
        lx = longint'($signed(x)); ly = longint'($signed(y));
        p = 64'(lx * ly); m.r = p[31:0]; m.rh = p[63:32];
      end
      T_UDIV: begin
        if (y == 0) begin m.r = '1; m.rh = x; m.dbz = 1'b1; end
        else begin m.r = x / y; m.rh = x % y; end
      end
      T_SDIV: begin
        sx = $signed(x); sy = $signed(y);
        if (y == 0) begin m.r = '1; m.rh = x; m.dbz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin m.r = x; m.rh = '0; end
        else begin m.r = sx / sy; m.rh = sx % sy; end
      end
      default: ;
    endcase
    if (is_div(o) && !DIV_EN) begin
      m.r = '0; m.rh = '0; m.dbz = 1'b0;
    end
    m.fl[3] = long_op ? m.rh[31] : m.r[31];
    m.fl[2] = long_op ? ({m.rh, m.r} == 64'd0) : (m.r == 0);
    return m;
  endfunction

  // Issue one op (start high for exactly one edge), return outputs sampled in the done cycle.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, y,
                       output res_t got, output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      busy_ok &= busy;
    end
    if (!done) lat = -1;
    got = mk(result, result_hi, div_by_zero, flags);
  endtask

  task automatic check_res(input string tag, input res_t got, input res_t exp,
                           input int lat, input int elat);
    check({tag, " result"},      64'(got.r),   64'(exp.r));
    check({tag, " result_hi"},   64'(got.rh),  64'(exp.rh));
    check({tag, " div_by_zero"}, 64'(got.dbz), 64'(exp.dbz));
    check({tag, " flags"},       64'(got.fl),  64'(exp.fl));
    check({tag, " latency"},     64'(lat),     64'(elat));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin : main
    vec_t  vecs[12];
    logic [2:0] ops[5];
    res_t  got, exp;
    int    lat, cyc;
    bit    busy_ok, saw_done;

    ops = '{T_MUL, T_UMULL, T_SMULL, T_UDIV, T_SDIV};
    vecs[0]  = '{T_SMULL, 32'hFFFF_FFFD, 32'd7,        mk(32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 4'b1000)};
    vecs[1]  = '{T_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 4'b1000)};
    vecs[2]  = '{T_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0001, 32'h0,         1'b0, 4'b0000)};
    vecs[3]  = '{T_UDIV,  32'd100,       32'd7,        dv(32'd14,        32'd2,         1'b0, 4'b0000)};
    vecs[4]  = '{T_SDIV,  32'hFFFF_FF9C, 32'd7,        dv(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 4'b1000)};
    vecs[5]  = '{T_UDIV,  32'd5,         32'd0,        dv(32'hFFFF_FFFF, 32'd5,         1'b1, 4'b1000)};
    vecs[6]  = '{T_SDIV,  32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000, 32'h0,         1'b0, 4'b1000)};
    vecs[7]  = '{T_UMULL, 32'd0,         32'd12345,    mk(32'h0,         32'h0,         1'b0, 4'b0100)};
    vecs[8]  = '{T_SMULL, 32'h8000_0000, 32'h8000_0000, mk(32'h0,         32'h4000_0000, 1'b0, 4'b0000)};
    vecs[9]  = '{T_MUL,   32'h0001_0000, 32'h0001_0000, mk(32'h0,         32'h0,         1'b0, 4'b0100)};
    vecs[10] = '{T_SMULL, 32'd0,         32'hFFFF_FFFB, mk(32'h0,         32'h0,         1'b0, 4'b0100)};
    vecs[11] = '{T_SDIV,  32'd7,         32'hFFFF_FFFE, dv(32'hFFFF_FFFD, 32'd1,         1'b0, 4'b1000)};

    reset_n = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",  64'(busy), 64'd0);
    check("reset done",  64'(done), 64'd0);
    check("reset outs",  {result, result_hi}, 64'd0);
    check("reset flags", 64'({flags, div_by_zero}), 64'd0);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, got, lat, busy_ok);
      check_res($sformatf("vec%0d", i), got, vecs[i].exp, lat, exp_lat(vecs[i].op));
      check($sformatf("vec%0d busy", i), 64'(busy_ok), 64'd1);
    end

    // Done pulse lasts one cycle when nothing follows.
    @(posedge clk); #1;
    check("done pulse width", 64'({done, busy}), 64'd0);

    // Second start while busy is ignored; first operands stay in use.
    @(negedge clk);
    start = 1'b1; op = T_SMULL; a = 32'hFFFF_FFFD; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1; op = T_UMULL; a = 32'h1234_5678; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    check("busy-start latency", 64'(lat), 64'(W + 2));
    check("busy-start result", {result_hi, result}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(posedge clk); #1;
    check("busy-start no rerun", 64'({done, busy}), 64'd0);

    // Start in the done cycle: do_op asserts start on the negedge inside the done cycle.
    do_op(T_UMULL, 32'd3, 32'd4, got, lat, busy_ok);
    check_res("pre-b2b", got, mk(32'd12, 32'd0, 1'b0, 4'b0000), lat, W + 2);
    do_op(T_MUL, 32'd6, 32'd7, got, lat, busy_ok);
    check_res("b2b", got, mk(32'd42, 32'd0, 1'b0, 4'b0000), lat, W + 2);

    // Illegal op is ignored and outputs hold.
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("illegal no done", 64'(done), 64'd0);
    check("illegal hold", {result_hi, result}, 64'd42);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; op = T_SMULL; a = 32'hFFFF_FFFD; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("midrst busy/done", 64'({busy, done}), 64'd0);
    check("midrst outs", {result, result_hi}, 64'd0);
    check("midrst flags", 64'({flags, div_by_zero}), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    saw_done = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst no done", 64'(saw_done), 64'd0);
    do_op(T_SMULL, 32'hFFFF_FFFD, 32'd7, got, lat, busy_ok);
    check_res("post-rst", got, mk(32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 4'b1000), lat, W + 2);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 250; i++) begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      o = ops[$urandom_range(0, 4)];
      x = pick_operand();
      y = pick_operand();
      exp = model(o, x, y);
      do_op(o, x, y, got, lat, busy_ok);
      check_res($sformatf("rnd%0d op=%b a=%h b=%h", i, o, x, y), got, exp, lat, exp_lat(o));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
